// File: rtl/nibble_serial_alu_seq.sv
// nibble_serial_alu_seq
// Sequences an N-nibble unsigned add/subtract through an external
// combinational 4-bit ALU, LSB nibble first, one nibble per clock.
// The carry or borrow between nibbles is held in an internal register.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; ALU operand drives are zero
// RUN   | one nibble per cycle through the ALU, result built up in place
// FIN   | done pulse; result/carry/zero held; start accepted back-to-back
module nibble_serial_alu_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   op,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic                   alu_op,
    input  logic [3:0]             alu_out,
    input  logic                   alu_flag,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   carry,
    output logic                   zero
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [W-1:0]     a_lat;
    logic [W-1:0]     b_lat;
    logic             op_lat;
    logic [IDX_W-1:0] idx;
    logic             c;

    logic [3:0]       nib_next;
    logic             c_next;
    logic [W-1:0]     word_next;

    // ALU operand slices are only presented while running; otherwise zero
    always_comb begin
        alu_a  = 4'h0;
        alu_b  = 4'h0;
        alu_op = op_lat;
        if (state == RUN) begin
            alu_a = a_lat[{idx, 2'b00} +: 4];
            alu_b = b_lat[{idx, 2'b00} +: 4];
        end
    end

    // fold the ripple carry/borrow into the ALU result for the current nibble
    always_comb begin
        nib_next  = 4'h0;
        c_next    = 1'b0;
        word_next = result;
        if (op_lat) begin
            nib_next = alu_out - {3'b000, c};
            c_next   = alu_flag | (c & (alu_out == 4'h0));
        end else begin
            nib_next = alu_out + {3'b000, c};
            c_next   = alu_flag | (c & (alu_out == 4'hF));
        end
        word_next[{idx, 2'b00} +: 4] = nib_next;
    end

    // control FSM with registered handshake and result outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            a_lat  <= '0;
            b_lat  <= '0;
            op_lat <= 1'b0;
            idx    <= '0;
            c      <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        a_lat  <= a;
                        b_lat  <= b;
                        op_lat <= op;
                        idx    <= '0;
                        c      <= 1'b0;
                        result <= '0;
                        carry  <= 1'b0;
                        zero   <= 1'b0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    result <= word_next;
                    c      <= c_next;
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        carry <= c_next;
                        zero  <= (word_next == '0);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_alu_seq.sv
module tb_nibble_serial_alu_seq;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk;
    logic         reset;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic         alu_op;
    logic [3:0]   alu_out;
    logic         alu_flag;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;

    int errors = 0;
    int checks = 0;

    nibble_serial_alu_seq #(.NIBBLES(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_out  (alu_out),
        .alu_flag (alu_flag),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit ALU: add gives carry out, subtract gives borrow (a < b)
    always_comb begin
        logic [4:0] s;
        s = 5'h0;
        if (alu_op) begin
            s[3:0] = alu_a - alu_b;
            s[4]   = (alu_a < alu_b);
        end else begin
            s = {1'b0, alu_a} + {1'b0, alu_b};
        end
        alu_out  = s[3:0];
        alu_flag = s[4];
    end

    function automatic logic [W:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic o);
        logic [W:0] s;
        if (o) begin
            s[W-1:0] = x - y;
            s[W]     = (x < y);
        end else begin
            s = {1'b0, x} + {1'b0, y};
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // issue one operation and follow it until done (bounded)
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic o,
                          output int lat, output int busy_cnt, output logic [15:0] seq,
                          output int overlap);
        start = 1'b1;
        a     = x;
        b     = y;
        op    = o;
        step();
        start    = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        seq      = 16'h0;
        overlap  = 0;
        while (!done && lat < 20) begin
            if (busy) begin
                busy_cnt++;
                seq = {seq[11:0], alu_a};
            end
            step();
            lat++;
        end
        if (busy && done) overlap++;
    endtask

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vop;
        logic [W-1:0] exp_res;
        logic         exp_cy;
        logic         exp_z;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int lat;
        int bc;
        int ov;
        int dcnt;
        logic [15:0] seq;
        logic [W:0] r;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic ro;
        logic [W-1:0] cap;

        vecs[0] = '{16'h1234, 16'h0FFF, 1'b1, 16'h0235, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[3] = '{16'hA5A5, 16'hA5A5, 1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[8] = '{16'h0100, 16'h0001, 1'b1, 16'h00FF, 1'b0, 1'b0};
        vecs[9] = '{16'h0001, 16'hFFFF, 1'b1, 16'h0002, 1'b1, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check("reset_outputs", {busy, done, carry, zero, result, alu_a, alu_b, alu_op},
              '0);
        reset = 1'b0;
        step();
        step();
        check("idle_outputs", {busy, done, alu_a, alu_b}, '0);

        // table-driven directed vectors
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vop, lat, bc, seq, ov);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(N + 1));
            check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(N));
            check($sformatf("vec%0d_result", i), 64'(result), 64'(vecs[i].exp_res));
            check($sformatf("vec%0d_carry", i), 64'(carry), 64'(vecs[i].exp_cy));
            check($sformatf("vec%0d_zero", i), 64'(zero), 64'(vecs[i].exp_z));
            check($sformatf("vec%0d_done_busy_overlap", i), 64'(ov), 64'(0));
            if (i == 0) begin
                check("vec0_alu_a_seq", 64'(seq), 64'h4321);
            end
            step();
            check($sformatf("vec%0d_done_pulse_width", i), 64'(done), 64'(0));
            check($sformatf("vec%0d_idle_alu_a", i), 64'(alu_a), 64'(0));
            check($sformatf("vec%0d_alu_op_held", i), 64'(alu_op), 64'(vecs[i].vop));
            check($sformatf("vec%0d_result_held", i), 64'(result), 64'(vecs[i].exp_res));
        end

        // start pulsed with new operands during RUN is ignored
        start = 1'b1; a = 16'h1234; b = 16'h0FFF; op = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; op = 1'b0;
        step();
        start = 1'b0;
        dcnt = 0;
        cap  = '0;
        for (int k = 0; k < 10; k++) begin
            if (done) begin
                dcnt++;
                cap = result;
            end
            step();
        end
        check("run_start_ignored_done_count", 64'(dcnt), 64'(1));
        check("run_start_ignored_result", 64'(cap), 64'h0235);
        check("run_start_ignored_carry", 64'(carry), 64'(0));

        // asynchronous reset in the middle of RUN
        start = 1'b1; a = 16'h1111; b = 16'h1111; op = 1'b0;
        step();
        start = 1'b0;
        step();
        step();
        #2;
        check("pre_reset_partial", 64'(result), 64'h0022);
        reset = 1'b1;
        #1;
        check("async_reset_outputs", {busy, done, carry, zero, result, alu_a, alu_b, alu_op},
              '0);
        #4;
        reset = 1'b0;
        dcnt  = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (done || busy) dcnt++;
        end
        check("post_reset_quiet", 64'(dcnt), 64'(0));
        run_op(16'h1111, 16'h1111, 1'b0, lat, bc, seq, ov);
        check("post_reset_op", {lat[3:0], carry, zero, result}, {4'd5, 1'b0, 1'b0, 16'h2222});
        step();

        // back-to-back: start held high through FIN
        start = 1'b1; a = 16'h1234; b = 16'h0FFF; op = 1'b1;
        step();
        lat = 1;
        while (!done && lat < 20) begin
            step();
            lat++;
        end
        check("b2b_first_latency", 64'(lat), 64'(N + 1));
        check("b2b_first_result", 64'(result), 64'h0235);
        a = 16'h1111; b = 16'h2222; op = 1'b0;
        step();
        check("b2b_no_gap", {busy, done}, 2'b10);
        lat = 1;
        while (!done && lat < 20) begin
            step();
            lat++;
        end
        start = 1'b0;
        check("b2b_second_period", 64'(lat), 64'(N + 1));
        check("b2b_second_result", {carry, zero, result}, {1'b0, 1'b0, 16'h3333});
        step();
        check("b2b_back_to_idle", {busy, done}, 2'b00);

        // random sweep against the W-bit reference model
        for (int k = 0; k < 1000; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            ro = 1'($urandom_range(1, 0));
            r  = ref_op(ra, rb, ro);
            run_op(ra, rb, ro, lat, bc, seq, ov);
            check($sformatf("rand%0d_%h_%h_%0d", k, ra, rb, ro),
                  {lat[3:0], carry, zero, result},
                  {4'd5, r[W], (r[W-1:0] == '0), r[W-1:0]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
